pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 91, sets the payload width in bits (range 1..256).
REQ-002 Parameter FLUSH_VALUE, default 0, is the WIDTH-bit payload loaded on flush and on reset.
REQ-003 Parameter CNT_W, default 16, sets the stall-counter width (range 1..32).
REQ-004 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  is the synchronous, active-high reset.
REQ-006 Port in_valid  input  1  means the upstream stage offers in_data this cycle.
REQ-007 Port in_ready  output  1  means the stage accepts in_data this cycle.
REQ-008 Port in_data  input  WIDTH  is the upstream payload.
REQ-009 Port out_valid  output  1  means out_data holds a valid downstream payload.
REQ-010 Port out_ready  input  1  means downstream consumes out_data this cycle.
REQ-011 Port out_data  output  WIDTH  is the registered payload to the next stage.
REQ-012 Port flush  input  1  discards all held and offered payloads (branch or jump squash).
REQ-013 Port stall_clr  input  1  clears the stall counter.
REQ-014 Port stall_cnt  output  CNT_W  counts cycles with out_valid=1 and out_ready=0.

Function
REQ-015 An input transfer occurs on an edge with in_valid=1 and in_ready=1; an output transfer occurs on an edge with out_valid=1 and out_ready=1.
REQ-016 out_data and out_valid come only from registers; there is no combinational path from in_data to out_data.
REQ-017 Latency: a payload accepted at edge N is presented on out_data after edge N, when the stage was empty or drained at N.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
REQ-019 Payloads leave in acceptance order; none is duplicated or lost except by flush or reset.
REQ-020 flush=1 at an edge clears every valid bit, loads FLUSH_VALUE into out_data, and drops that cycle's input transfer; flush beats any simultaneous input or output transfer.
REQ-021 After the flush edge, in_ready follows its empty-state value; stall_cnt is not affected by flush.
REQ-022 When out_valid=0, out_data keeps its last value and is don't-care for consumers.
REQ-023 stall_cnt increments by 1 per edge with out_valid=1, out_ready=0 and flush=0.
REQ-024 stall_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-025 stall_clr=1 sets stall_cnt to 0 at that edge, overriding any increment in the same cycle.

Reset
REQ-026 reset=1 at an edge sets out_valid=0, out_data=FLUSH_VALUE, stall_cnt=0, and sets any skid entry invalid.
REQ-027 reset overrides flush, stall_clr and any transfer in the same cycle.
REQ-028 In the cycle after reset deasserts, in_ready=1.
REQ-029 Reset mid-stall discards the held payload.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN compiles in a one-entry skid register.
- Defined: states are EMPTY, MAIN (out_valid only) and FULL (main plus skid).
- Defined: in_ready is registered and equals "skid not valid".
- Defined: input arrives in MAIN while out_ready=0 -> skid captures it, state becomes FULL.
- Defined: output transfer in FULL -> skid moves to main, state becomes MAIN.
- Defined: simultaneous input and output transfer in MAIN -> input goes to main.
- Defined: throughput is 1 payload per cycle.
REQ-031 Without PIPE_STAGE_SKID_EN the block has a single register.
- in_ready = out_ready OR NOT out_valid, a combinational path.
- Simultaneous input and output transfer replaces the payload.
- Throughput is 1 payload per cycle.

Verification
REQ-032 Stream: reset, then in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data shows 1,2,3,4 one cycle later each, with out_valid continuously 1.
REQ-033 Back-pressure: data 0x7F accepted, then out_ready=0 for 5 cycles.
- out_data stays 0x7F and stall_cnt reaches 5.
- With SKID_EN, a second payload 0x08 fills the skid and in_ready falls one cycle later.
- On out_ready=1, 0x7F then 0x08 emerge.
REQ-034 Flush while full (with SKID_EN, main 0x17 and skid 0x08 held), flush=1 with in_valid=1 data 0x99 -> next cycle out_valid=0, out_data=FLUSH_VALUE, in_ready=1, and 0x99 is never output.
REQ-035 Saturation: CNT_W=3 with out_ready=0 for 10 cycles -> stall_cnt=7; stall_clr=1 in the same cycle as a stall -> stall_cnt=0.
REQ-036 Reset mid-operation: main and skid full and stall_cnt=4, reset=1 together with flush=1 and in_valid=1 -> out_valid=0, stall_cnt=0, out_data=FLUSH_VALUE, and in_ready=1 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 91,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  // Stall counter ignores flush except that a flushing cycle never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    MAIN,
    FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;

  // in_ready is a register tracking "skid empty", so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= FLUSH_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= MAIN;
          end
        end
        MAIN: begin
          if (out_ready) begin
            if (in_valid) begin
              out_data <= in_data;
            end else begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end else if (in_valid) begin
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= MAIN;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`else

  assign in_ready = out_ready || !out_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_data  <= FLUSH_VALUE;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: queue-based reference model plus directed scenarios.
// Follows PIPE_STAGE_SKID_EN to pick the stage capacity and in_ready rule.
module tb_pipe_stage_reg;
  localparam int unsigned W       = 16;
  localparam logic [W-1:0] FV     = 16'hA5A5;
  localparam int          CNT_MAX = 65535;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, flush, stall_clr;
  logic [W-1:0] in_data, out_data;
  logic [15:0]  stall_cnt;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush, s_stall_clr;
  logic [7:0] s_in_data, s_out_data;
  logic [2:0] s_stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] shown;
  int           exp_cnt;
  bit           mon_en = 1'b0;
  bit           m_rdy, m_ix, m_ox;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .FLUSH_VALUE(FV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .FLUSH_VALUE(8'h3C), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .flush(s_flush), .stall_clr(s_stall_clr), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_in_ready();
    if (CAP == 2) return exp_q.size() < 2;
    return out_ready || exp_q.size() == 0;
  endfunction

  // Reference model: the stage is a FIFO of capacity CAP.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      shown   = FV;
      exp_cnt = 0;
    end else begin
      if (stall_clr) exp_cnt = 0;
      else if (exp_q.size() > 0 && !out_ready && !flush && exp_cnt < CNT_MAX) exp_cnt++;
      if (flush) begin
        exp_q.delete();
        shown = FV;
      end else begin
        m_rdy = model_in_ready();
        m_ix  = in_valid && m_rdy;
        m_ox  = exp_q.size() > 0 && out_ready;
        if (m_ox) void'(exp_q.pop_front());
        if (m_ix) exp_q.push_back(in_data);
        if (exp_q.size() > 0) shown = exp_q[0];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("out_data",  64'(out_data),  64'(shown));
      check("in_ready",  64'(in_ready),  64'(model_in_ready()));
      check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0; s_stall_clr = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'(FV));
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Stream 1..4 at full rate.
    out_ready = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      in_valid = 1'b1; in_data = W'(d);
      cyc();
      check("stream_data", 64'(out_data), 64'(d));
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // Back-pressure: 0x7F held for 5 stalled edges, 0x08 offered behind it.
    in_valid = 1'b1; in_data = 16'h007F;
    cyc();
    out_ready = 1'b0; in_data = 16'h0008;
    cyc();
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (4) cyc();
    check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    check("bp_hold", 64'(out_data), 64'h7F);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // Flush while occupied, with a competing input transfer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0017;
    cyc();
    in_data = 16'h0008;
    cyc();
    flush = 1'b1; in_data = 16'h0099;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data", 64'(out_data), 64'(FV));
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(); cyc();

    // Reset beats flush and input with the stage loaded and stall_cnt at 4.
    out_ready = 1'b0; stall_clr = 1'b1;
    in_valid = 1'b1; in_data = 16'h0017;
    cyc();
    stall_clr = 1'b0; in_data = 16'h0008;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    check("pre_rst_cnt", 64'(stall_cnt), 64'd4);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 16'h0099;
    cyc();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_cnt", 64'(stall_cnt), 64'd0);
    check("midrst_data", 64'(out_data), 64'(FV));
    check("midrst_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic: light then heavy back-pressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = W'($urandom);
      out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = $urandom_range(0, 40) == 0;
      stall_clr = $urandom_range(0, 30) == 0;
      reset     = $urandom_range(0, 250) == 0;
      cyc();
    end
    reset = 1'b0; flush = 1'b0; stall_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    // Saturation with a 3-bit counter.
    s_in_valid = 1'b1; s_in_data = 8'h05;
    cyc();
    s_in_valid = 1'b0;
    repeat (10) cyc();
    check("sat_cnt", 64'(s_stall_cnt), 64'd7);
    check("sat_hold", 64'(s_out_data), 64'h05);
    check("sat_valid", 64'(s_out_valid), 64'd1);
    s_stall_clr = 1'b1;
    cyc();
    check("sat_clr", 64'(s_stall_cnt), 64'd0);
    s_stall_clr = 1'b0;
    cyc();
    check("sat_after_clr", 64'(s_stall_cnt), 64'd1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
